// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit-counter width for a given operand width.
  function automatic int unsigned cnt_w(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Combinational 1-bit full adder used as the serial adder's arithmetic cell.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock through a single fa_cell.
// Optional two's-complement overflow output enabled by SERIAL_ADDER_OVF_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CNT_W = cnt_w(WIDTH);

  state_t             state;
  state_t             state_nxt;
  logic               load_c;
  logic               shift_c;
  logic               last_c;

  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-2:0]   s_sh;
  logic [WIDTH-1:0]   s_word_c;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic               fa_s;
  logic               fa_co;

  fa_cell u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // Partial sum with the current bit shifted in at the MSB.
  assign s_word_c = {fa_s, s_sh};

  // State register; busy/done are registered decodes of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= (state_nxt == DONE);
    end
  end

  always_comb begin
    state_nxt = state;
    load_c    = 1'b0;
    shift_c   = 1'b0;
    last_c    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load_c    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        shift_c = 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) begin
          last_c    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand/partial-sum shifters, ripple carry and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (load_c) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (shift_c) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      s_sh  <= s_word_c[WIDTH-1:1];
      carry <= fa_co;
      cnt   <= cnt + CNT_W'(1);
    end
  end

  // Result registers only update on the final bit, so partial sums never leak out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf  <= 1'b0;
`endif
    end else if (last_c) begin
      sum  <= s_word_c;
      cout <= fa_co;
`ifdef SERIAL_ADDER_OVF_EN
      ovf  <= carry ^ fa_co;
`endif
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8).
module tb_serial_adder;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  int n_checks;
  int n_fail;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one cycle; returns after the accepting edge (+1).
  task automatic start_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv);
    @(posedge clk);
    #1;
    a = av; b = bv; cin = cv; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 8'h00; b = 8'h00; cin = 1'b0;
  endtask

  // Count edges until done is seen (sampled 1 after each edge); 0 on timeout.
  task automatic wait_done(output int edges);
    edges = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'($urandom_range(0, 1));
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom_range(0, 1));
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_checks++; if (sum !== 8'h00) begin n_fail++; $display("FAIL reset_sum got=%h exp=00", sum); end
    n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout got=%b exp=0", cout); end
`ifdef SERIAL_ADDER_OVF_EN
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
`endif
    start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add_vectors();
    logic [WIDTH-1:0] va [5] = '{8'h35, 8'hFF, 8'h7F, 8'hFF, 8'h80};
    logic [WIDTH-1:0] vb [5] = '{8'h4A, 8'h01, 8'h01, 8'hFF, 8'h80};
    logic             vc [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [WIDTH-1:0] es [5] = '{8'h7F, 8'h01, 8'h80, 8'hFF, 8'h00};
    logic             ec [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic             eo [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int edges;
    for (int i = 0; i < 5; i++) begin
      start_op(va[i], vb[i], vc[i]);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL add%0d_busy got=%b exp=1", i, busy); end
      wait_done(edges);
      n_checks++; if (edges != 8) begin n_fail++; $display("FAIL add%0d_latency got=%0d exp=8", i, edges); end
      n_checks++; if (sum !== es[i]) begin n_fail++; $display("FAIL add%0d_sum got=%h exp=%h", i, sum, es[i]); end
      n_checks++; if (cout !== ec[i]) begin n_fail++; $display("FAIL add%0d_cout got=%b exp=%b", i, cout, ec[i]); end
`ifdef SERIAL_ADDER_OVF_EN
      n_checks++; if (ovf !== eo[i]) begin n_fail++; $display("FAIL add%0d_ovf got=%b exp=%b", i, ovf, eo[i]); end
`else
      if (eo[i] === 1'bx) $display("unexpected x in overflow table");
`endif
      @(posedge clk);
      #1;
      n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL add%0d_pulse done=%b busy=%b exp=0/0", i, done, busy);
      end
    end
  endtask

  // Start held high throughout, operands changed mid-operation.
  task automatic test_start_held();
    int edges;
    @(posedge clk);
    #1;
    a = 8'h12; b = 8'h34; cin = 1'b1; start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    a = 8'hAA; b = 8'h55; cin = 1'b0;
    wait_done(edges);
    n_checks++; if (edges != 6) begin n_fail++; $display("FAIL held_latency got=%0d exp=6", edges); end
    n_checks++; if (sum !== 8'h47 || cout !== 1'b0) begin
      n_fail++; $display("FAIL held_result got=%b_%h exp=0_47", cout, sum);
    end
    @(posedge clk);
    #1;
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL held_idle done=%b busy=%b exp=0/0", done, busy);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL held_restart busy=%b exp=1", busy); end
    n_checks++; if (sum !== 8'h47) begin n_fail++; $display("FAIL held_sum_stable got=%h exp=47", sum); end
    wait_done(edges);
    n_checks++; if (edges != 8) begin n_fail++; $display("FAIL held2_latency got=%0d exp=8", edges); end
    n_checks++; if (sum !== 8'hFF || cout !== 1'b0) begin
      n_fail++; $display("FAIL held2_result got=%b_%h exp=0_ff", cout, sum);
    end
    @(posedge clk);
    #1;
  endtask

  // Reset asserted after three shift edges aborts the operation.
  task automatic test_reset_mid_op();
    int edges;
    start_op(8'h35, 8'h4A, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL midrst_ctrl busy=%b done=%b exp=0/0", busy, done);
    end
    n_checks++; if (sum !== 8'h00 || cout !== 1'b0) begin
      n_fail++; $display("FAIL midrst_result got=%b_%h exp=0_00", cout, sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(edges);
    n_checks++; if (edges != 0) begin n_fail++; $display("FAIL midrst_no_done got_edge=%0d exp=none", edges); end
    start_op(8'h0F, 8'h01, 1'b0);
    wait_done(edges);
    n_checks++; if (edges != 8) begin n_fail++; $display("FAIL midrst_fresh_latency got=%0d exp=8", edges); end
    n_checks++; if (sum !== 8'h10 || cout !== 1'b0) begin
      n_fail++; $display("FAIL midrst_fresh_result got=%b_%h exp=0_10", cout, sum);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    test_reset();
    test_add_vectors();
    test_start_held();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
